// File: rtl/soc_system_sysid_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp from the
// sysid slave, compares both against compiled-in values and holds the result.
module soc_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
    parameter logic [31:0] EXPECTED_TS    = 32'h54BE9BAE,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    // state  | meaning
    // IDLE   | waiting for start or the post-reset auto launch
    // RD_ID  | read request on address 0 (ID)
    // LAT_ID | counting slave latency for the ID word
    // RD_TS  | read request on address 1 (timestamp)
    // LAT_TS | counting slave latency for the timestamp word
    // DONE   | result held; first cycle here publishes done and match flags
    typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE} state_t;

    localparam logic [1:0]  LAT_LOAD   = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic        first_cycle;
    logic [15:0] stall_cnt;
    logic [1:0]  lat_cnt;
    logic        accept;
    logic        stall_hit;
    logic        cap_id;
    logic        cap_ts;
    logic        entering_rd;
    logic        launching;

    always_comb begin
        state_next  = state;
        avm_read    = 1'b0;
        avm_address = 1'b0;
        accept      = 1'b0;
        stall_hit   = 1'b0;
        cap_id      = 1'b0;
        cap_ts      = 1'b0;
        case (state)
            IDLE: begin
                if (start || (AUTO_START && first_cycle)) state_next = RD_ID;
            end
            RD_ID: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    accept = 1'b1;
                    if (READ_LATENCY == 0) begin
                        cap_id     = 1'b1;
                        state_next = RD_TS;
                    end else begin
                        state_next = LAT_ID;
                    end
                end else if (stall_cnt == STALL_LAST) begin
                    stall_hit  = 1'b1;
                    state_next = DONE;
                end
            end
            LAT_ID: begin
                if (lat_cnt == 2'd0) begin
                    cap_id     = 1'b1;
                    state_next = RD_TS;
                end
            end
            RD_TS: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
                if (!avm_waitrequest) begin
                    accept = 1'b1;
                    if (READ_LATENCY == 0) begin
                        cap_ts     = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = LAT_TS;
                    end
                end else if (stall_cnt == STALL_LAST) begin
                    stall_hit  = 1'b1;
                    state_next = DONE;
                end
            end
            LAT_TS: begin
                avm_address = 1'b1;
                if (lat_cnt == 2'd0) begin
                    cap_ts     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // done is still low on the first DONE cycle, so start is ignored there
                if (start && done) state_next = RD_ID;
            end
            default: state_next = IDLE;
        endcase
    end

    assign launching   = (state_next == RD_ID) && (state != RD_ID);
    assign entering_rd = launching || ((state_next == RD_TS) && (state != RD_TS));

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            first_cycle <= 1'b1;
            stall_cnt   <= '0;
            lat_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_match    <= 1'b0;
            ts_match    <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            state       <= state_next;
            first_cycle <= 1'b0;

            if (entering_rd || accept)             stall_cnt <= '0;
            else if (avm_read && avm_waitrequest)  stall_cnt <= stall_cnt + 16'd1;

            if (accept)                 lat_cnt <= LAT_LOAD;
            else if (lat_cnt != 2'd0)   lat_cnt <= lat_cnt - 2'd1;

            if (cap_id)    id_value    <= avm_readdata;
            if (cap_ts)    ts_value    <= avm_readdata;
            if (stall_hit) timeout_err <= 1'b1;

            if (launching) begin
                busy        <= 1'b1;
                done        <= 1'b0;
                id_match    <= 1'b0;
                ts_match    <= 1'b0;
                timeout_err <= 1'b0;
                id_value    <= '0;
                ts_value    <= '0;
            end else if (state == DONE && !done) begin
                busy     <= 1'b0;
                done     <= 1'b1;
                id_match <= !timeout_err && (id_value == EXPECTED_ID);
                ts_match <= !timeout_err && (ts_value == EXPECTED_TS);
            end
        end
    end

endmodule
